// File: rtl/serial_comp_pkg.sv
// Shared definitions for the word-framed serial complementer.
package serial_comp_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_PASS = 2'd0,
    MODE_NEG  = 2'd1,
    MODE_ONES = 2'd2,
    MODE_ABS  = 2'd3
  } mode_e;

endpackage

// File: rtl/serial_comp_if.sv
// Framed serial input/output bundle of the serial complementer.
interface serial_comp_if;

  logic                              in_valid;
  logic                              in_bit;
  logic                              in_sof;
  logic [serial_comp_pkg::MODE_W-1:0] mode;
  logic                              out_valid;
  logic                              out_bit;
  logic                              out_sof;
  logic                              out_eow;
  logic                              ovf;
  logic                              err_frame;

  modport master (
    output in_valid, in_bit, in_sof, mode,
    input  out_valid, out_bit, out_sof, out_eow, ovf, err_frame
  );

  modport slave (
    input  in_valid, in_bit, in_sof, mode,
    output out_valid, out_bit, out_sof, out_eow, ovf, err_frame
  );

endinterface

// File: rtl/serial_comp_core.sv
// Per-bit serial transform: two's complement via the "seen a one" flag q,
// or plain inversion / pass-through.
module serial_comp_core (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  input  logic negate,
  input  logic invert,
  input  logic x,
  output logic y
);

  logic q;
  logic q_eff;

  // start clears q combinationally so bit 0 of a word never sees the previous word's flag
  always_comb begin
    q_eff = start ? 1'b0 : q;
    y     = invert ? ~x : (x ^ (negate & q_eff));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= q_eff | x;
    end
  end

endmodule

// File: rtl/serial_comp_unit.sv
// Word-framed serial complementer: captures LSB-first words, then re-emits them
// transformed (pass / negate / invert / absolute) with framing and overflow.
module serial_comp_unit
  import serial_comp_pkg::*;
#(
  parameter int unsigned WORD_W = 8
) (
  input logic          clk,
  input logic          reset,
  serial_comp_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

  typedef enum logic {EMIT_IDLE, EMIT_RUN} emit_state_e;

  logic [CNT_W-1:0]  cnt;
  logic [WORD_W-2:0] cap;
  mode_e             cap_mode;
  logic              load;
  logic              err_d;
  logic [WORD_W-1:0] load_word;

  emit_state_e       state;
  emit_state_e       state_nx;
  logic [CNT_W-1:0]  ecnt;
  logic [WORD_W-1:0] esr;
  mode_e             emode;
  logic              esign;
  logic              active;
  logic              first;
  logic              last;
  logic              negate;
  logic              invert;
  logic              y;

  // Capture side: an in_sof bit always restarts the word, even mid-word
  always_comb begin
    load      = bus.in_valid && !bus.in_sof && (cnt == CNT_LAST);
    err_d     = bus.in_valid && ((bus.in_sof && (cnt != '0)) || (!bus.in_sof && (cnt == '0)));
    load_word = {bus.in_bit, cap};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      cap      <= '0;
      cap_mode <= MODE_PASS;
    end else if (bus.in_valid) begin
      if (bus.in_sof) begin
        cap[0]   <= bus.in_bit;
        cap_mode <= mode_e'(bus.mode);
        cnt      <= CNT_W'(1);
      end else if (cnt != '0) begin
        if (load) begin
          cnt <= '0;
        end else begin
          cap[cnt] <= bus.in_bit;
          cnt      <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Emit FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMIT_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Emit FSM: next state; a load on the last emit cycle keeps the run going gap-free
  always_comb begin
    state_nx = state;
    case (state)
      EMIT_IDLE: if (load) state_nx = EMIT_RUN;
      EMIT_RUN:  if (last && !load) state_nx = EMIT_IDLE;
      default:   state_nx = EMIT_IDLE;
    endcase
  end

  // Emit FSM: outputs
  always_comb begin
    active = (state == EMIT_RUN);
    first  = active && (ecnt == '0);
    last   = active && (ecnt == CNT_LAST);
    negate = (emode == MODE_NEG) || ((emode == MODE_ABS) && esign);
    invert = (emode == MODE_ONES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      esr   <= '0;
      ecnt  <= '0;
      emode <= MODE_PASS;
      esign <= 1'b0;
    end else if (load) begin
      esr   <= load_word;
      ecnt  <= '0;
      emode <= cap_mode;
      esign <= bus.in_bit;
    end else if (active) begin
      esr  <= esr >> 1;
      ecnt <= ecnt + CNT_W'(1);
    end
  end

  serial_comp_core u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (first),
    .en     (active),
    .negate (negate),
    .invert (invert),
    .x      (esr[0]),
    .y      (y)
  );

  // Outputs are registered; ovf flags a negated most-negative input (sign in and out both 1)
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_bit   <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eow   <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.err_frame <= 1'b0;
    end else begin
      bus.out_valid <= active;
      bus.out_bit   <= active & y;
      bus.out_sof   <= first;
      bus.out_eow   <= last;
      bus.ovf       <= last & negate & esr[0] & y;
      bus.err_frame <= err_d;
    end
  end

endmodule

// File: tb/tb_serial_comp_unit.sv
// Directed bench for serial_comp_unit at WORD_W=8 with hand-computed results.
module tb_serial_comp_unit;
  import serial_comp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  serial_comp_if bus ();

  serial_comp_unit #(.WORD_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned pcyc = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  // Output monitor: reassembles words and records their framing
  logic [7:0]  mon_acc = '0;
  int unsigned mon_pos = 8;
  logic        mon_ok = 1'b0;
  logic [7:0]  wq[$];
  logic        oq[$];
  logic        fq[$];
  int unsigned sq[$];
  int unsigned vcount = 0;
  int unsigned errcount = 0;
  int unsigned stray = 0;

  always @(negedge clk) begin
    if (bus.err_frame) errcount++;
    if (bus.out_valid) begin
      vcount++;
      if (bus.out_sof) begin
        mon_pos = 0;
        mon_ok  = 1'b1;
        sq.push_back(pcyc);
      end
      if (mon_pos < 8) begin
        mon_acc[mon_pos] = bus.out_bit;
        if (bus.out_eow != (mon_pos == 7)) mon_ok = 1'b0;
        if (bus.ovf && (mon_pos != 7)) mon_ok = 1'b0;
        if (mon_pos == 7) begin
          wq.push_back(mon_acc);
          oq.push_back(bus.ovf);
          fq.push_back(mon_ok);
        end
        mon_pos++;
      end else begin
        stray++;
      end
    end else if (bus.out_sof || bus.out_eow || bus.ovf || bus.out_bit) begin
      stray++;
    end
  end

  task automatic drive(input logic v, input logic b, input logic s, input logic [1:0] m);
    bus.in_valid = v;
    bus.in_bit   = b;
    bus.in_sof   = s;
    bus.mode     = m;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic [1:0] m);
    for (int i = 0; i < 8; i++) drive(1'b1, w[i], (i == 0), m);
  endtask

  task automatic idle(input int unsigned n);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_bit   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fetch(output logic got, output logic [7:0] w, output logic o, output logic f);
    int unsigned n = 0;
    got = 1'b0; w = '0; o = 1'b0; f = 1'b0;
    while ((wq.size() == 0) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    if (wq.size() != 0) begin
      got = 1'b1;
      w   = wq.pop_front();
      o   = oq.pop_front();
      f   = fq.pop_front();
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b1; bus.in_sof = 1'b1; bus.in_bit = 1'b1; bus.mode = MODE_NEG;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_bit, bus.out_sof, bus.out_eow, bus.ovf, bus.err_frame} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 000000",
               {bus.out_valid, bus.out_bit, bus.out_sof, bus.out_eow, bus.ovf, bus.err_frame});
    end
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_bit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_bit, bus.out_sof, bus.out_eow, bus.ovf, bus.err_frame} !== 6'b0) begin
      bad++;
      $display("FAIL post_reset_outputs: got %b want 000000",
               {bus.out_valid, bus.out_bit, bus.out_sof, bus.out_eow, bus.ovf, bus.err_frame});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_neg();
    logic got, o, f;
    logic [7:0] w;
    int unsigned t;
    sq.delete();
    send_word(8'h05, MODE_NEG);
    t = pcyc;
    idle(12);
    fetch(got, w, o, f);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL neg_arrive: got %b want 1", got); end
    total++; if (w !== 8'hFB) begin bad++; $display("FAIL neg_word: got %h want fb", w); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL neg_ovf: got %b want 0", o); end
    total++; if (f !== 1'b1) begin bad++; $display("FAIL neg_framing: got %b want 1", f); end
    total++;
    if ((sq.size() !== 1) || (sq[0] !== t + 1)) begin
      bad++;
      $display("FAIL neg_latency: got sofs=%0d first=%0d want sof at %0d", sq.size(),
               (sq.size() != 0) ? sq[0] : 0, t + 1);
    end
  endtask

  task automatic test_back_to_back();
    logic got, o, f;
    logic [7:0] w;
    int unsigned t, v0;
    sq.delete();
    v0 = vcount;
    send_word(8'hF6, MODE_ABS);
    send_word(8'h0A, MODE_ABS);
    t = pcyc;
    idle(14);
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'h0A, 1'b0, 1'b1}) begin
      bad++; $display("FAIL abs_neg_word: got arrive=%b w=%h ovf=%b frm=%b want 1 0a 0 1", got, w, o, f);
    end
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'h0A, 1'b0, 1'b1}) begin
      bad++; $display("FAIL abs_pos_word: got arrive=%b w=%h ovf=%b frm=%b want 1 0a 0 1", got, w, o, f);
    end
    total++;
    if ((sq.size() !== 2) || (sq[1] !== sq[0] + 8) || (sq[1] !== t + 1)) begin
      bad++;
      $display("FAIL b2b_gapless: got sofs=%0d at %0d,%0d want 2 at %0d,%0d", sq.size(),
               (sq.size() > 0) ? sq[0] : 0, (sq.size() > 1) ? sq[1] : 0, t - 7, t + 1);
    end
    total++;
    if (vcount - v0 !== 16) begin bad++; $display("FAIL b2b_valid_cycles: got %0d want 16", vcount - v0); end
  endtask

  task automatic test_modes_ovf();
    logic got, o, f;
    logic [7:0] w;
    send_word(8'h80, MODE_NEG);
    idle(2);
    send_word(8'h80, MODE_ONES);
    idle(2);
    send_word(8'h3C, MODE_PASS);
    idle(12);
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'h80, 1'b1, 1'b1}) begin
      bad++; $display("FAIL neg_min_ovf: got arrive=%b w=%h ovf=%b frm=%b want 1 80 1 1", got, w, o, f);
    end
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'h7F, 1'b0, 1'b1}) begin
      bad++; $display("FAIL ones_word: got arrive=%b w=%h ovf=%b frm=%b want 1 7f 0 1", got, w, o, f);
    end
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'h3C, 1'b0, 1'b1}) begin
      bad++; $display("FAIL pass_word: got arrive=%b w=%h ovf=%b frm=%b want 1 3c 0 1", got, w, o, f);
    end
  endtask

  task automatic test_stall();
    logic got, o, f;
    logic [7:0] w;
    logic [7:0] src;
    int unsigned t;
    sq.delete();
    src = 8'h01;
    for (int i = 0; i < 5; i++) drive(1'b1, src[i], (i == 0), MODE_NEG);
    idle(3);
    for (int i = 5; i < 8; i++) drive(1'b1, src[i], 1'b0, MODE_NEG);
    t = pcyc;
    idle(12);
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'hFF, 1'b0, 1'b1}) begin
      bad++; $display("FAIL stall_word: got arrive=%b w=%h ovf=%b frm=%b want 1 ff 0 1", got, w, o, f);
    end
    total++;
    if ((sq.size() !== 1) || (sq[0] !== t + 1)) begin
      bad++;
      $display("FAIL stall_latency: got sofs=%0d first=%0d want sof at %0d", sq.size(),
               (sq.size() != 0) ? sq[0] : 0, t + 1);
    end
  endtask

  task automatic test_framing();
    logic got, o, f;
    logic [7:0] w;
    int unsigned e0, v0;
    e0 = errcount;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, (i == 0), MODE_ONES);
    send_word(8'h05, MODE_NEG);
    idle(12);
    total++; if (errcount - e0 !== 1) begin bad++; $display("FAIL sof_err_pulse: got %0d cycles want 1", errcount - e0); end
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'hFB, 1'b0, 1'b1}) begin
      bad++; $display("FAIL sof_restart_word: got arrive=%b w=%h ovf=%b frm=%b want 1 fb 0 1", got, w, o, f);
    end
    e0 = errcount;
    v0 = vcount;
    drive(1'b1, 1'b1, 1'b0, MODE_NEG);
    idle(12);
    total++; if (errcount - e0 !== 1) begin bad++; $display("FAIL stray_err_pulse: got %0d cycles want 1", errcount - e0); end
    total++; if (vcount - v0 !== 0) begin bad++; $display("FAIL stray_no_output: got %0d valid cycles want 0", vcount - v0); end
    // the ignored bit must not have advanced the counter: a clean word follows
    send_word(8'h3C, MODE_NEG);
    idle(12);
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'hC4, 1'b0, 1'b1}) begin
      bad++; $display("FAIL after_stray_word: got arrive=%b w=%h ovf=%b frm=%b want 1 c4 0 1", got, w, o, f);
    end
  endtask

  task automatic test_reset_mid();
    logic got, o, f;
    logic [7:0] w;
    int unsigned v0;
    send_word(8'h05, MODE_NEG);
    idle(3);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.out_valid, bus.out_bit, bus.out_sof, bus.out_eow, bus.ovf, bus.err_frame} !== 6'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got %b want 000000",
               {bus.out_valid, bus.out_bit, bus.out_sof, bus.out_eow, bus.ovf, bus.err_frame});
    end
    v0 = vcount;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(12);
    total++; if (vcount - v0 !== 0) begin bad++; $display("FAIL midreset_lost: got %0d valid cycles want 0", vcount - v0); end
    total++; if (wq.size() !== 0) begin bad++; $display("FAIL midreset_no_word: got %0d words want 0", wq.size()); end
    send_word(8'hA5, MODE_PASS);
    idle(12);
    fetch(got, w, o, f);
    total++; if ({got, w, o, f} !== {1'b1, 8'hA5, 1'b0, 1'b1}) begin
      bad++; $display("FAIL fresh_word: got arrive=%b w=%h ovf=%b frm=%b want 1 a5 0 1", got, w, o, f);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    bus.in_sof   = 1'b0;
    bus.mode     = MODE_PASS;
    test_reset();
    test_neg();
    test_back_to_back();
    test_modes_ovf();
    test_stall();
    test_framing();
    test_reset_mid();
    total++;
    if (stray !== 0) begin bad++; $display("FAIL stray_outputs: got %0d want 0", stray); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_comp_unit.md
Name: serial_comp_unit

Overview:
Parametrised, word-framed serial complementer; the next generation of the team's single-bit serial two's complementer. It accepts LSB-first serial words of WORD_W bits with start-of-word framing. It applies a per-word mode: pass, two's complement, one's complement or absolute value. Each word is re-emitted LSB-first, framed, with an overflow flag. It sits between serial ADC/link deserialisers and serial arithmetic datapaths.

Parameters:
WORD_W, 8, bits per serial word (legal range 2..32)
CNT_W, $clog2(WORD_W), bit-counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_bit is a valid data bit this cycle
in_bit  input  1  serial data, LSB first
in_sof  input  1  qualifies in_valid; marks bit 0 of a word
mode  input  2  transform select, sampled with the in_sof bit
out_valid  output  1  out_bit valid
out_bit  output  1  transformed serial data, LSB first
out_sof  output  1  with out_valid, marks output bit 0
out_eow  output  1  with out_valid, marks output bit WORD_W-1
ovf  output  1  with out_eow; result not representable
err_frame  output  1  one-cycle pulse on framing violation

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Reset clears all state. While in reset and on the first cycle after it, out_valid, out_bit, out_sof, out_eow, ovf and err_frame are all 0. Any partial input word and any word mid-emission are discarded.
- Modes (enum): 0 PASS (y=x); 1 NEG, two's complement; 2 ONES (y=~x); 3 ABS (NEG if word sign bit is 1, else PASS).
- Capture side:
  - The bit counter advances only on in_valid. in_valid may drop mid-word; this is a stall, and the counter and partial word hold.
  - The in_sof bit is stored as bit 0, and mode is latched.
  - When bit WORD_W-1 is captured, the word and its mode move to the emit buffer on the same edge, and the counter returns to 0.
- Emit side:
  - Emission starts the cycle after transfer and runs WORD_W consecutive cycles with out_valid=1. There are no output stalls.
  - Latency: the last input bit at edge t gives output bit 0 valid after edge t+1.
  - Back-to-back words at full rate emit with no gap. The double buffer (capture register plus emit shift register) never overruns, because input rate is at most 1 bit/cycle.
- Serial NEG core:
  - Flag q is cleared at output bit 0.
  - y = x XOR q, then q <= q OR x. This holds for NEG, and for ABS when the sign is 1.
- Overflow: ovf=1 on out_eow only when negation was applied and both input and output sign bits are 1. This is the most-negative value, 1 followed by WORD_W-1 zeros. ovf is 0 otherwise and 0 for PASS/ONES.
- Framing errors (each pulses err_frame for one cycle, next cycle registered):
  - in_sof with counter≠0: the partial word is dropped and the new word starts with this bit as bit 0.
  - in_valid without in_sof at counter=0: the bit is ignored and the counter stays 0.
- Simultaneous events: the transfer edge for word N, while word N-1's last bit is emitting, is legal. The emit register reloads on the edge after out_eow.

Decomposition:
- Package serial_comp_pkg holds:
  - the mode enum: MODE_PASS=0, MODE_NEG=1, MODE_ONES=2, MODE_ABS=3;
  - the localparam for the mode width.
- One sub-module, serial_comp_core: the per-bit transform with the q flag. Its inputs are clk, reset, start (clear q), en, negate, invert and x; its output is y. Framing, counters and buffers stay in the top.

Test Plan:
- W=8, NEG, 0x05 (bits 1,0,1,0,0,0,0,0) -> 0xFB. out_sof on the first output cycle, out_eow on the 8th, ovf=0.
- ABS on 0xF6 -> 0x0A, then ABS on 0x0A -> 0x0A. Words are back-to-back; output is 16 contiguous valid cycles.
- NEG 0x80 -> 0x80 with ovf=1 at out_eow; ONES 0x80 -> 0x7F with ovf=0; PASS 0x3C -> 0x3C.
- in_valid deasserted for 3 cycles after bit 4 of 0x01 in NEG -> output still 0xFF. Output starts 1 cycle after the final input bit.
- in_sof reasserted at bit 3 -> err_frame pulse, partial word dropped, the new word is correct. A valid bit with no sof at idle -> err_frame, no output.
- reset asserted mid-emission -> next cycle all outputs 0, the remaining bits are lost. A fresh word after reset processes normally.
